gpio_led_burst_ctrl: RTL
========================

// Module: gpio_led_burst_ctrl
// PURPOSE
//  Fabric-side consumer of the MSS subsystem outputs. Synchronises GPIO_7_M2F,
//  detects its rising edges and, per edge, drives a timed LED blink burst
//  (ON/OFF phases repeated BURST_LEN times). Runs on FAB_CCC_GL0 and is gated
//  by MSS_READY and FAB_CCC_LOCK. Queues one edge that arrives mid-burst and
//  flags any further overrun.
// PARAMETERS
//  ON_CYCLES   12500000  LED-high cycles per pulse (>=1)
//  OFF_CYCLES  12500000  LED-low cycles per pulse (>=1)
//  BURST_LEN   3         pulses per burst (>=1)
//  CNT_W       24        phase counter width; must hold max(ON,OFF)-1
// PORTS
//  CLK_BASE     in   1  fabric clock (FAB_CCC_GL0)
//  FAB_RESET_N  in   1  synchronous, active-low reset
//  GPIO_7_M2F   in   1  MSS GPIO, asynchronous to CLK_BASE
//  MSS_READY    in   1  MSS ready; enables the block when high
//  FAB_CCC_LOCK in   1  CCC lock; enables the block when high
//  LED          out  1  LED drive, active-high
//  BUSY         out  1  high while a burst is in progress
//  PENDING      out  1  one burst is queued
//  OVERRUN      out  1  sticky: an edge arrived with the queue full
//  EDGE_CNT     out  8  count of accepted rising edges, wraps 255->0
// BEHAVIOUR
//  Reset: all flops clear on the CLK_BASE edge with FAB_RESET_N=0.
//   Output reset values: LED=0, BUSY=0, PENDING=0, OVERRUN=0, EDGE_CNT=0.
//   Synchroniser reset value: s1=s2=s3=0.
//  Sync chain: s1<=GPIO; s2<=s1; s3<=s2. rise = s2 & ~s3.
//   The chain runs continuously, including while disabled, so re-enabling
//   never produces a false edge.
//  en = MSS_READY & FAB_CCC_LOCK, used combinationally.
//  Latency: GPIO sampled high at edge k -> LED=1 after edge k+2 (idle case).
//  FSM states: IDLE, ON, OFF.
//   Counters: ph_cnt (CNT_W bits), pulse_cnt (ceil(log2(BURST_LEN+1)) bits).
//   IDLE: when en & (rise | PENDING): enter ON, ph_cnt=0, pulse_cnt=0, LED=1,
//    clear PENDING. If PENDING and rise occur together, PENDING stays set.
//   ON: when ph_cnt==ON_CYCLES-1: enter OFF, ph_cnt=0, LED=0.
//    Otherwise increment ph_cnt.
//   OFF: when ph_cnt==OFF_CYCLES-1 and pulse_cnt==BURST_LEN-1: enter IDLE.
//    When ph_cnt==OFF_CYCLES-1 otherwise: enter ON, pulse_cnt+1, LED=1.
//    Otherwise increment ph_cnt.
//  Result: LED is high for exactly ON_CYCLES cycles per pulse.
//   Burst length = BURST_LEN*(ON_CYCLES+OFF_CYCLES) cycles.
//   A queued burst starts on the cycle after IDLE is entered.
//  BUSY = (state!=IDLE), registered together with the state.
//  Rise while en and state!=IDLE: set PENDING if clear; otherwise set OVERRUN.
//  EDGE_CNT increments on every rise while en, whether started, queued or
//   overrun.
//  en low in any state: next cycle state=IDLE, LED=0, PENDING=0.
//   EDGE_CNT and OVERRUN are kept. Rises while en=0 are ignored and not counted.
//  Reset in any state behaves as the reset case above.
// TESTING (ON=4, OFF=3, BURST_LEN=2, en=1 unless stated)
//  1 Single rise -> LED high 4 / low 3 / high 4 / low 3; BUSY high 14 cycles;
//    EDGE_CNT=1.
//  2 Second rise at burst cycle 5 -> PENDING=1; second burst starts 1 cycle
//    after BUSY falls; EDGE_CNT=2, OVERRUN=0.
//  3 Three rises within one burst -> PENDING=1, OVERRUN=1 (sticky until
//    reset), EDGE_CNT=3, exactly 2 bursts emitted.
//  4 MSS_READY=0 at burst cycle 6 -> LED=0, BUSY=0, PENDING=0 next cycle;
//    GPIO held high across re-enable -> no new burst.
//  5 FAB_CCC_LOCK=0, GPIO toggled 5x -> LED stays 0, EDGE_CNT unchanged.
//  6 256 accepted rises -> EDGE_CNT wraps to 0; FAB_RESET_N=0 mid-burst ->
//    all outputs 0 on the next edge.

Source files
------------

// File: rtl/gpio_led_burst_ctrl.sv
// rtl/gpio_led_burst_ctrl.sv - GPIO rise-triggered LED blink burst controller with one-deep queue
module gpio_led_burst_ctrl #(
    parameter int ON_CYCLES  = 12500000,
    parameter int OFF_CYCLES = 12500000,
    parameter int BURST_LEN  = 3,
    parameter int CNT_W      = 24
) (
    input  logic       CLK_BASE,
    input  logic       FAB_RESET_N,
    input  logic       GPIO_7_M2F,
    input  logic       MSS_READY,
    input  logic       FAB_CCC_LOCK,
    output logic       LED,
    output logic       BUSY,
    output logic       PENDING,
    output logic       OVERRUN,
    output logic [7:0] EDGE_CNT
);
    localparam int PW = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] PH_ONE     = CNT_W'(1);
    localparam logic [PW-1:0]    PULSE_LAST = PW'(BURST_LEN - 1);
    localparam logic [PW-1:0]    PULSE_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    logic             s1_q;
    logic             s2_q;
    logic             s3_q;
    state_t           state_q;
    logic [CNT_W-1:0] ph_cnt_q;
    logic [PW-1:0]    pulse_cnt_q;
    logic             led_q;
    logic             busy_q;
    logic             pending_q;
    logic             overrun_q;
    logic [7:0]       edge_cnt_q;
    logic             en;
    logic             rise;

    assign en   = MSS_READY & FAB_CCC_LOCK;
    assign rise = s2_q & ~s3_q;

    // Chain keeps running while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge CLK_BASE) begin
        if (!FAB_RESET_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= GPIO_7_M2F;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge CLK_BASE) begin
        if (!FAB_RESET_N) begin
            state_q     <= ST_IDLE;
            ph_cnt_q    <= '0;
            pulse_cnt_q <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            edge_cnt_q  <= 8'd0;
        end else if (!en) begin
            state_q   <= ST_IDLE;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (rise) begin
                edge_cnt_q <= edge_cnt_q + 8'd1;
            end
            if (rise && (state_q != ST_IDLE)) begin
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    pending_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (rise || pending_q) begin
                        state_q     <= ST_ON;
                        ph_cnt_q    <= '0;
                        pulse_cnt_q <= '0;
                        led_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        // A fresh edge landing on a queued start stays queued.
                        pending_q   <= pending_q & rise;
                    end
                end
                ST_ON: begin
                    if (ph_cnt_q == ON_LAST) begin
                        state_q  <= ST_OFF;
                        ph_cnt_q <= '0;
                        led_q    <= 1'b0;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PH_ONE;
                    end
                end
                ST_OFF: begin
                    if (ph_cnt_q == OFF_LAST) begin
                        ph_cnt_q <= '0;
                        if (pulse_cnt_q == PULSE_LAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= ST_ON;
                            pulse_cnt_q <= pulse_cnt_q + PULSE_ONE;
                            led_q       <= 1'b1;
                        end
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PH_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign LED      = led_q;
    assign BUSY     = busy_q;
    assign PENDING  = pending_q;
    assign OVERRUN  = overrun_q;
    assign EDGE_CNT = edge_cnt_q;

endmodule
